// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: CPU loads/stores and debug word accesses share one
// req/ack memory port, with lane steering, load extension, pipeline stall and timeout.
module dmem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int NB_TO      = 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_alu,
  input  logic [DATA_WIDTH-1:0] i_data2,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_err,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [DATA_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_done,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    DBG_ACC  = 2'd2,
    CPU_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [NB_TO-1:0]   timeoutCnt_q;
  logic [2:0]         func3_q;
  logic [1:0]         offset_q;
  logic               isLoad_q;

  logic                  cpuReq;
  logic                  funcLegal;
  logic                  misaligned;
  logic                  cpuLegal;
  logic                  timeoutHit;
  logic [3:0]            storeBe;
  logic [DATA_WIDTH-1:0] storeWdata;
  logic [DATA_WIDTH-1:0] shiftedRdata;
  logic [DATA_WIDTH-1:0] loadExt;

  assign cpuReq     = i_memRead | i_memWrite;
  assign timeoutHit = (timeoutCnt_q == NB_TO'(TIMEOUT - 1));
  assign o_stall    = i_rst_n & (((state_q == IDLE) & cpuReq) | (state_q == CPU_ACC));

  // Unsigned load variants only exist for loads, so they are illegal on the store path.
  always_comb begin
    funcLegal = 1'b0;
    case (i_func3)
      3'b000, 3'b001, 3'b010: funcLegal = 1'b1;
      3'b100, 3'b101:         funcLegal = i_memRead & ~i_memWrite;
      default:                funcLegal = 1'b0;
    endcase
    misaligned = ((i_func3[1:0] == 2'b01) & i_alu[0]) |
                 ((i_func3[1:0] == 2'b10) & (i_alu[1:0] != 2'b00));
    cpuLegal   = funcLegal & ~misaligned & ~(i_memRead & i_memWrite);
  end

  always_comb begin
    storeBe    = 4'b1111;
    storeWdata = i_data2;
    case (i_func3[1:0])
      2'b00: begin
        storeBe    = 4'b0001 << i_alu[1:0];
        storeWdata = {4{i_data2[7:0]}};
      end
      2'b01: begin
        storeBe    = 4'b0011 << i_alu[1:0];
        storeWdata = {2{i_data2[15:0]}};
      end
      default: begin
        storeBe    = 4'b1111;
        storeWdata = i_data2;
      end
    endcase
  end

  // Extension uses the func3/offset latched at issue, not the live pipeline inputs.
  always_comb begin
    shiftedRdata = i_mem_rdata >> {offset_q, 3'b000};
    loadExt      = shiftedRdata;
    case (func3_q)
      3'b000:  loadExt = {{24{shiftedRdata[7]}}, shiftedRdata[7:0]};
      3'b001:  loadExt = {{16{shiftedRdata[15]}}, shiftedRdata[15:0]};
      3'b100:  loadExt = {24'b0, shiftedRdata[7:0]};
      3'b101:  loadExt = {16'b0, shiftedRdata[15:0]};
      default: loadExt = shiftedRdata;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      timeoutCnt_q <= '0;
      func3_q      <= '0;
      offset_q     <= '0;
      isLoad_q     <= 1'b0;
      o_rdata      <= '0;
      o_rvalid     <= 1'b0;
      o_err        <= 1'b0;
      o_dbg_gnt    <= 1'b0;
      o_dbg_done   <= 1'b0;
      o_dbg_rdata  <= '0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_be     <= '0;
    end else begin
      o_rvalid   <= 1'b0;
      o_err      <= 1'b0;
      o_dbg_gnt  <= 1'b0;
      o_dbg_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpuReq) begin
            func3_q  <= i_func3;
            offset_q <= i_alu[1:0];
            isLoad_q <= i_memRead;
            if (cpuLegal) begin
              state_q      <= CPU_ACC;
              timeoutCnt_q <= '0;
              o_mem_req    <= 1'b1;
              o_mem_we     <= i_memWrite;
              o_mem_addr   <= {i_alu[DATA_WIDTH-1:2], 2'b00};
              o_mem_wdata  <= i_memWrite ? storeWdata : '0;
              o_mem_be     <= i_memWrite ? storeBe : 4'b0000;
            end else begin
              state_q  <= CPU_DONE;
              o_rvalid <= 1'b1;
              o_err    <= 1'b1;
              o_rdata  <= '0;
            end
          end else if (i_dbg_req) begin
            state_q      <= DBG_ACC;
            timeoutCnt_q <= '0;
            o_dbg_gnt    <= 1'b1;
            o_mem_req    <= 1'b1;
            o_mem_we     <= i_dbg_we;
            o_mem_addr   <= {i_dbg_addr[DATA_WIDTH-1:2], 2'b00};
            o_mem_wdata  <= i_dbg_wdata;
            o_mem_be     <= i_dbg_we ? 4'b1111 : 4'b0000;
          end
        end
        CPU_ACC: begin
          if (i_mem_ack || timeoutHit) begin
            state_q      <= CPU_DONE;
            timeoutCnt_q <= '0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_be     <= 4'b0000;
            o_rvalid     <= 1'b1;
            o_err        <= ~i_mem_ack;
            o_rdata      <= (i_mem_ack && isLoad_q) ? loadExt : '0;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        DBG_ACC: begin
          if (i_mem_ack || timeoutHit) begin
            state_q      <= IDLE;
            timeoutCnt_q <= '0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_be     <= 4'b0000;
            o_dbg_done   <= 1'b1;
            o_dbg_rdata  <= (i_mem_ack && !o_mem_we) ? i_mem_rdata : '0;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        CPU_DONE: begin
          // One bubble so the still-present EX/MEM instruction is not re-issued.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a vector table of single CPU accesses plus
// hand-written timeout, debug-arbitration and mid-access reset sequences.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        i_rst_n;
  logic        i_memRead;
  logic        i_memWrite;
  logic [2:0]  i_func3;
  logic [31:0] i_alu;
  logic [31:0] i_data2;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_err;
  logic        i_dbg_req;
  logic        i_dbg_we;
  logic [31:0] i_dbg_addr;
  logic [31:0] i_dbg_wdata;
  logic        o_dbg_gnt;
  logic        o_dbg_done;
  logic [31:0] o_dbg_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int checks;
  int errors;

  dmem_access_ctrl #(
    .DATA_WIDTH(32),
    .TIMEOUT   (4),
    .NB_TO     (8)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_memRead  (i_memRead),
    .i_memWrite (i_memWrite),
    .i_func3    (i_func3),
    .i_alu      (i_alu),
    .i_data2    (i_data2),
    .o_stall    (o_stall),
    .o_rdata    (o_rdata),
    .o_rvalid   (o_rvalid),
    .o_err      (o_err),
    .i_dbg_req  (i_dbg_req),
    .i_dbg_we   (i_dbg_we),
    .i_dbg_addr (i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_gnt  (o_dbg_gnt),
    .o_dbg_done (o_dbg_done),
    .o_dbg_rdata(o_dbg_rdata),
    .o_mem_req  (o_mem_req),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_be   (o_mem_be),
    .i_mem_ack  (i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data2;
    logic [31:0] memRd;
    logic        legal;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
    logic [31:0] expRdata;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];
  vec_t v;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] d2);
    i_memRead  = rd;
    i_memWrite = wr;
    i_func3    = f3;
    i_alu      = addr;
    i_data2    = d2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    i_rst_n     = 1'b0;
    i_dbg_req   = 1'b0;
    i_dbg_we    = 1'b0;
    i_dbg_addr  = '0;
    i_dbg_wdata = '0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);

    //            rd    wr    f3      addr       data2         memRd         legal expAddr    expWdata      expBe    expRdata
    vecs[0]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1'b0, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b0, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b0, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1'b0, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        1'b0, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b1, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1'b1, 32'h100, 32'hA5A5A5A5, 4'b1000, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0,        32'h0080FF00, 1'b1, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80};
    vecs[8]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h0080FF00, 1'b1, 32'h100, 32'h0,        4'b0000, 32'h00000080};
    vecs[9]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h0080FF00, 1'b1, 32'h100, 32'h0,        4'b0000, 32'h00000080};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 1'b1, 32'h100, 32'h0,        4'b0000, 32'hFFFF8001};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1'b1, 32'h100, 32'hABCDABCD, 4'b1100, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b010, 32'h20C, 32'h11223344, 32'h0,        1'b1, 32'h20C, 32'h11223344, 4'b1111, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h100, 32'hFFFFFF3C, 32'h0,        1'b1, 32'h100, 32'h3C3C3C3C, 4'b0001, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h12345678, 1'b1, 32'h100, 32'h0,        4'b0000, 32'h00000056};

    // Reset state, with a read request already present: stall must stay low.
    #12;
    checkOutput("rst_stall", o_stall, 0);
    checkOutput("rst_req", o_mem_req, 0);
    checkOutput("rst_rvalid", o_rvalid, 0);
    checkOutput("rst_be", o_mem_be, 0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      v = vecs[i];
      applyStimulus(v.rd, v.wr, v.f3, v.addr, v.data2);
      i_mem_ack   = 1'b1;
      i_mem_rdata = v.memRd;
      #1;
      checkOutput($sformatf("v%0d_stall_idle", i), o_stall, 1);
      tick();
      if (v.legal) begin
        checkOutput($sformatf("v%0d_req", i), o_mem_req, 1);
        checkOutput($sformatf("v%0d_we", i), o_mem_we, v.wr);
        checkOutput($sformatf("v%0d_addr", i), o_mem_addr, v.expAddr);
        checkOutput($sformatf("v%0d_be", i), o_mem_be, v.expBe);
        if (v.wr) checkOutput($sformatf("v%0d_wdata", i), o_mem_wdata, v.expWdata);
        checkOutput($sformatf("v%0d_stall_acc", i), o_stall, 1);
        checkOutput($sformatf("v%0d_rvalid_early", i), o_rvalid, 0);
        tick();
        checkOutput($sformatf("v%0d_rvalid", i), o_rvalid, 1);
        checkOutput($sformatf("v%0d_err", i), o_err, 0);
        checkOutput($sformatf("v%0d_req_done", i), o_mem_req, 0);
        checkOutput($sformatf("v%0d_stall_done", i), o_stall, 0);
        if (v.rd) checkOutput($sformatf("v%0d_rdata", i), o_rdata, v.expRdata);
      end else begin
        checkOutput($sformatf("v%0d_ill_rvalid", i), o_rvalid, 1);
        checkOutput($sformatf("v%0d_ill_err", i), o_err, 1);
        checkOutput($sformatf("v%0d_ill_req", i), o_mem_req, 0);
        checkOutput($sformatf("v%0d_ill_stall", i), o_stall, 0);
        checkOutput($sformatf("v%0d_ill_rdata", i), o_rdata, 0);
      end
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      i_mem_ack = 1'b0;
      tick();
      checkOutput($sformatf("v%0d_rvalid_pulse", i), o_rvalid, 0);
      checkOutput($sformatf("v%0d_err_pulse", i), o_err, 0);
    end

    // Timeout: with TIMEOUT=4 the request is held exactly four ACC cycles, then aborts.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    i_mem_rdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("to_req_c%0d", c), o_mem_req, 1);
      checkOutput($sformatf("to_stall_c%0d", c), o_stall, 1);
      checkOutput($sformatf("to_rvalid_c%0d", c), o_rvalid, 0);
    end
    tick();
    checkOutput("to_req_drop", o_mem_req, 0);
    checkOutput("to_rvalid", o_rvalid, 1);
    checkOutput("to_err", o_err, 1);
    checkOutput("to_rdata", o_rdata, 0);
    checkOutput("to_stall", o_stall, 0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();

    // CPU and debug request together: CPU first, grant only after CPU_DONE.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    i_dbg_req   = 1'b1;
    i_dbg_we    = 1'b0;
    i_dbg_addr  = 32'h00000043;
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'hCAFEF00D;
    tick();
    checkOutput("arb_gnt_acc", o_dbg_gnt, 0);
    checkOutput("arb_cpu_addr", o_mem_addr, 32'h100);
    tick();
    checkOutput("arb_gnt_done", o_dbg_gnt, 0);
    checkOutput("arb_cpu_rvalid", o_rvalid, 1);
    checkOutput("arb_cpu_rdata", o_rdata, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checkOutput("arb_gnt_idle", o_dbg_gnt, 0);
    checkOutput("arb_req_idle", o_mem_req, 0);
    i_mem_rdata = 32'h0BADC0DE;
    tick();
    checkOutput("dbg_gnt", o_dbg_gnt, 1);
    checkOutput("dbg_req", o_mem_req, 1);
    checkOutput("dbg_addr", o_mem_addr, 32'h40);
    checkOutput("dbg_we", o_mem_we, 0);
    checkOutput("dbg_be_rd", o_mem_be, 4'b0000);
    checkOutput("dbg_stall", o_stall, 0);
    tick();
    i_dbg_req = 1'b0;
    checkOutput("dbg_done", o_dbg_done, 1);
    checkOutput("dbg_gnt_pulse", o_dbg_gnt, 0);
    checkOutput("dbg_rdata", o_dbg_rdata, 32'h0BADC0DE);
    checkOutput("dbg_req_drop", o_mem_req, 0);
    checkOutput("dbg_no_rvalid", o_rvalid, 0);

    // Debug write: word-only, full byte enables, address low bits cleared.
    i_dbg_req   = 1'b1;
    i_dbg_we    = 1'b1;
    i_dbg_addr  = 32'h00000207;
    i_dbg_wdata = 32'h55AA55AA;
    tick();
    checkOutput("dbgw_gnt", o_dbg_gnt, 1);
    checkOutput("dbgw_we", o_mem_we, 1);
    checkOutput("dbgw_addr", o_mem_addr, 32'h204);
    checkOutput("dbgw_be", o_mem_be, 4'b1111);
    checkOutput("dbgw_wdata", o_mem_wdata, 32'h55AA55AA);
    tick();
    i_dbg_req = 1'b0;
    i_dbg_we  = 1'b0;
    checkOutput("dbgw_done", o_dbg_done, 1);
    tick();
    checkOutput("dbgw_done_pulse", o_dbg_done, 0);

    // Reset asserted during CPU_ACC drops req and stall without waiting for a clock.
    i_mem_ack = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    checkOutput("mid_req", o_mem_req, 1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", o_mem_req, 0);
    checkOutput("mid_rst_stall", o_stall, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    i_rst_n = 1'b1;
    tick();
    checkOutput("post_rst_req", o_mem_req, 0);
    checkOutput("post_rst_rvalid", o_rvalid, 0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h13579BDF;
    #1;
    checkOutput("post_rst_stall", o_stall, 1);
    tick();
    checkOutput("post_rst_issue", o_mem_req, 1);
    checkOutput("post_rst_addr", o_mem_addr, 32'h400);
    tick();
    checkOutput("post_rst_rvalid2", o_rvalid, 1);
    checkOutput("post_rst_rdata", o_rdata, 32'h13579BDF);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    i_mem_ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
